// File: rtl/d8m_qsys_nios2_qsys_div_cell.sv
// Sequential radix-2 restoring divider for the Nios II div/divu custom instructions.
// One operand pair per start pulse; fixed 34-cycle latency from start to the done strobe.
module d8m_qsys_nios2_qsys_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_cell_result,
  output logic [WIDTH-1:0] A_div_cell_remainder
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    src1_d      = src1_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    mag1    = (A_div_signed && A_div_src1[WIDTH-1]) ? -A_div_src1 : A_div_src1;
    mag2    = (A_div_signed && A_div_src2[WIDTH-1]) ? -A_div_src2 : A_div_src2;
    // The partial remainder never exceeds the divisor, so bit WIDTH of trial is a clean sign bit.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};

    unique case (state_q)
      IDLE: begin
        if (A_div_start) begin
          quo_d   = mag1;
          dvsr_d  = mag2;
          rem_d   = '0;
          cnt_d   = '0;
          src1_d  = A_div_src1;
          q_neg_d = A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
          r_neg_d = A_div_signed & A_div_src1[WIDTH-1];
          dz_d    = (A_div_src2 == '0);
          state_d = ITER;
        end
      end
      ITER: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          result_d    = '1;
          remainder_d = src1_q;
        end else begin
          result_d    = q_neg_q ? -quo_q : quo_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      src1_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      src1_q      <= src1_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign A_div_busy           = (state_q != IDLE);
  assign A_div_done           = done_q;
  assign A_div_cell_result    = result_q;
  assign A_div_cell_remainder = remainder_q;

endmodule

// File: tb/tb_d8m_qsys_nios2_qsys_div_cell.sv
// Directed self-checking bench for the sequential divider: cycle-exact busy/done timing,
// signed/unsigned results, divide-by-zero, overflow, handshake and mid-operation reset.
module tb_d8m_qsys_nios2_qsys_div_cell;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result, remainder;

  int checks   = 0;
  int failures = 0;

  d8m_qsys_nios2_qsys_div_cell #(.WIDTH(32)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .A_div_start          (start),
    .A_div_signed         (sgn),
    .A_div_src1           (src1),
    .A_div_src2           (src2),
    .A_div_busy           (busy),
    .A_div_done           (done),
    .A_div_cell_result    (result),
    .A_div_cell_remainder (remainder)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs and samples sit 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start in the current cycle N; returns in cycle N+1.
  task automatic pulse_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    sgn   = s;
    src1  = a;
    src2  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle N+1; checks busy/done through N+33, then results in N+34 and returns there.
  task automatic finish_op(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
    for (int k = 1; k <= 33; k++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, "_quot"}, result, exp_q);
    check({tag, "_rem"}, remainder, exp_r);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r);
    pulse_start(s, a, b);
    finish_op(tag, exp_q, exp_r);
    tick();
    check({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_quot"}, result, exp_q);
    check({tag, "_hold_rem"}, remainder, exp_r);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    sgn     = 1'b0;
    src1    = '0;
    src2    = '0;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", result, 32'd0);
    check("reset_rem", remainder, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("udiv_basic", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("sdiv_negnum", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("sdiv_negden", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_op("sdiv_bothneg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    run_op("udiv_zero", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("sdiv_zero", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("sdiv_zero_neg", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321);
    run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("udiv_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("udiv_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // Start while busy is ignored; start in the done cycle is accepted.
    pulse_start(1'b0, 32'd100, 32'd7);            // start at N, now N+1
    for (int k = 1; k < 10; k++) tick();          // now N+10
    pulse_start(1'b1, 32'd999, 32'd3);            // ignored, now N+11
    check("hs_busy_after_ignored", {31'd0, busy}, 32'd1);
    for (int k = 11; k < 34; k++) tick();         // now N+34
    check("hs_done", {31'd0, done}, 32'd1);
    check("hs_quot", result, 32'd14);
    check("hs_rem", remainder, 32'd2);
    pulse_start(1'b1, 32'hFFFF_FF9C, 32'd7);      // accepted at N+34, now N+35
    finish_op("b2b", 32'hFFFF_FFF2, 32'hFFFF_FFFE); // done at N+68
    tick();

    // Reset for one cycle at N+15 aborts the operation without a done pulse.
    pulse_start(1'b0, 32'd50, 32'd5);             // now N+1
    for (int k = 1; k < 15; k++) tick();          // now N+15
    reset_n = 1'b0;
    tick();                                       // now N+16
    reset_n = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", result, 32'd0);
    check("rst_rem", remainder, 32'd0);
    for (int k = 0; k < 40; k++) begin
      check("rst_no_done", {31'd0, done}, 32'd0);
      check("rst_no_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    run_op("after_rst", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
